// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scaler_pkg
// Description : Shared types and helpers for the image scaler engine.
//               Contains the scaling-mode enum, the control FSM state enum,
//               the accumulator width and the output-dimension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

  localparam int SCALER_PIX_W    = 8;
  localparam int SCALER_MAX_LOG2 = 3;

  // A full F*F block of maximum pixels must fit: F*F = 2^(2*MAX_LOG2).
  function automatic int acc_width(input int pix_w, input int max_log2);
    return pix_w + 2 * max_log2;
  endfunction

  localparam int ACC_W = acc_width(SCALER_PIX_W, SCALER_MAX_LOG2);

  typedef enum logic [1:0] {
    MODE_AVG_DOWN = 2'd0,
    MODE_DEC_DOWN = 2'd1,
    MODE_REP_UP   = 2'd2,
    MODE_COPY     = 2'd3
  } scaler_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } scaler_state_e;

  // Output dimension for one axis; computed at 32 bits so an oversize
  // result is still visible to the configuration check.
  function automatic logic [31:0] out_dim(input scaler_mode_e mode,
                                          input logic [1:0]   k,
                                          input logic [31:0]  dim);
    logic [31:0] r;
    unique case (mode)
      MODE_AVG_DOWN, MODE_DEC_DOWN: r = dim >> k;
      MODE_REP_UP:                  r = dim << k;
      default:                      r = dim;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : scaler_addr_gen
// Description : Output-pixel (ox/oy) and in-block (dx/dy) counters plus the
//               source/destination address arithmetic of the scaler.
// Ports       : clk, rst_n      clock, async active-low reset
//               clear           zero all counters (frame start)
//               rd_step         one source read issued this cycle
//               wr_step         one output write accepted this cycle
//               mode, k         latched scaling mode and log2 factor
//               src_width       latched source width
//               out_width/height output frame dimensions
//               rd_addr/wr_addr source / destination addresses
//               rd_last         current read is the last of this pixel
//               wr_last         current pixel is the last of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_addr_gen
  import scaler_pkg::*;
#(
  parameter int DIM_W    = 10,
  parameter int ADDR_W   = 16,
  parameter int MAX_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      rd_step,
  input  logic                      wr_step,
  input  scaler_mode_e              mode,
  input  logic [1:0]                k,
  input  logic [DIM_W-1:0]          src_width,
  input  logic [DIM_W+MAX_LOG2-1:0] out_width,
  input  logic [DIM_W+MAX_LOG2-1:0] out_height,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      rd_last,
  output logic                      wr_last
);

  localparam int OW = DIM_W + MAX_LOG2;
  localparam int DW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [DW-1:0] dx_q, dx_d, dy_q, dy_d;

  logic [1:0]    w_blk;
  logic [DW-1:0] w_blk_max;
  logic [OW-1:0] w_ox_max, w_oy_max;
  logic [31:0]   w_sx, w_sy, w_rd_lin, w_wr_lin;

  // Only block averaging walks a multi-pixel block; every other mode reads
  // a single source pixel per output pixel.
  always_comb begin
    w_blk     = (mode == MODE_AVG_DOWN) ? k : 2'd0;
    w_blk_max = DW'((32'd1 << w_blk) - 32'd1);
    w_ox_max  = out_width - OW'(1);
    w_oy_max  = out_height - OW'(1);
    rd_last   = (dx_q == w_blk_max) && (dy_q == w_blk_max);
    wr_last   = (ox_q == w_ox_max) && (oy_q == w_oy_max);
  end

  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      ox_d = '0;
      oy_d = '0;
      dx_d = '0;
      dy_d = '0;
    end else begin
      if (rd_step) begin
        // dx fastest; both wrap to zero after the final read of the block
        if (dx_q == w_blk_max) begin
          dx_d = '0;
          dy_d = (dy_q == w_blk_max) ? '0 : dy_q + DW'(1);
        end else begin
          dx_d = dx_q + DW'(1);
        end
      end
      if (wr_step) begin
        if (ox_q == w_ox_max) begin
          ox_d = '0;
          oy_d = (oy_q == w_oy_max) ? '0 : oy_q + OW'(1);
        end else begin
          ox_d = ox_q + OW'(1);
        end
      end
    end
  end

  always_comb begin
    w_sx = 32'(ox_q);
    w_sy = 32'(oy_q);
    unique case (mode)
      MODE_AVG_DOWN: begin
        w_sx = (32'(ox_q) << k) + 32'(dx_q);
        w_sy = (32'(oy_q) << k) + 32'(dy_q);
      end
      MODE_DEC_DOWN: begin
        w_sx = 32'(ox_q) << k;
        w_sy = 32'(oy_q) << k;
      end
      MODE_REP_UP: begin
        w_sx = 32'(ox_q) >> k;
        w_sy = 32'(oy_q) >> k;
      end
      default: ;
    endcase
    w_rd_lin = w_sy * 32'(src_width) + w_sx;
    w_wr_lin = 32'(oy_q) * 32'(out_width) + 32'(ox_q);
    rd_addr  = ADDR_W'(w_rd_lin);
    wr_addr  = ADDR_W'(w_wr_lin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q <= '0;
      oy_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      ox_q <= ox_d;
      oy_q <= oy_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_scaler_engine.sv
`default_nettype none
// ============================================================================
// Module      : image_scaler_engine
// Description : Streaming power-of-two image scaler (block-average down,
//               decimation down, replication up, copy) between a 1-cycle
//               latency source memory and a backpressured output buffer.
// Ports       : clk, rst_n             clock, async active-low reset
//               start, mode, log2_factor, src_width, src_height
//                                      frame launch and configuration
//               rd_en, rd_addr, rd_data source read port
//               wr_en, wr_addr, wr_data, wr_ready  output write port
//               busy, done, err        host status
// Config      : SCALER_ROUND_EN - round-half-up block averages instead of
//               truncating them.
// Revision    : 1.0 - initial release
// ============================================================================
module image_scaler_engine
  import scaler_pkg::*;
#(
  parameter int PIX_W    = SCALER_PIX_W,
  parameter int DIM_W    = 10,
  parameter int ADDR_W   = 16,
  parameter int MAX_LOG2 = SCALER_MAX_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [1:0]        log2_factor,
  input  logic [DIM_W-1:0]  src_width,
  input  logic [DIM_W-1:0]  src_height,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int OW    = DIM_W + MAX_LOG2;
  localparam int SUM_W = acc_width(PIX_W, MAX_LOG2);

  scaler_state_e    state_q, state_d;
  scaler_mode_e     mode_q, mode_d;
  logic [1:0]       k_q, k_d;
  logic [DIM_W-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic             err_q, err_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;

  logic [31:0]      w_out_w32, w_out_h32, w_k32, w_mask;
  logic [OW-1:0]    w_out_w, w_out_h;
  logic [63:0]      w_area;
  logic             w_down, w_bad;
  logic [SUM_W:0]   w_sum, w_sum_rnd;
  logic [2:0]       w_shift;
  logic [PIX_W-1:0] w_pix;
  logic             w_clear, w_rd_step, w_wr_step, w_rd_last, w_wr_last;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;

  // ---------------------------------------------------------------- config
  always_comb begin
    w_out_w32 = out_dim(mode_q, k_q, 32'(src_w_q));
    w_out_h32 = out_dim(mode_q, k_q, 32'(src_h_q));
    w_out_w   = OW'(w_out_w32);
    w_out_h   = OW'(w_out_h32);
    w_k32     = 32'(k_q);
    w_mask    = (32'd1 << k_q) - 32'd1;
    w_down    = (mode_q == MODE_AVG_DOWN) || (mode_q == MODE_DEC_DOWN);
    w_area    = 64'(w_out_w32) * 64'(w_out_h32);
    w_bad     = (src_w_q == '0) || (src_h_q == '0)
             || (w_k32 > 32'(MAX_LOG2))
             || (w_down && (((32'(src_w_q) & w_mask) != 32'd0) ||
                            ((32'(src_h_q) & w_mask) != 32'd0)))
             || (w_area > (64'd1 << ADDR_W));
  end

  // ----------------------------------------------------------- pixel value
  // In DRAIN the final rd_data has not been folded into acc_q yet, so the
  // complete sum is formed here. Non-averaging modes use a zero shift and
  // simply pass the single sample through.
  always_comb begin
    w_shift = (mode_q == MODE_AVG_DOWN) ? {k_q, 1'b0} : 3'd0;
    w_sum   = {1'b0, acc_q} + (SUM_W+1)'(rd_data);
`ifdef SCALER_ROUND_EN
    w_sum_rnd = (w_shift != 3'd0)
              ? w_sum + ((SUM_W+1)'(1) << (w_shift - 3'd1))
              : w_sum;
`else
    w_sum_rnd = w_sum;
`endif
    w_pix = PIX_W'(w_sum_rnd >> w_shift);
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    k_d        = k_q;
    src_w_d    = src_w_q;
    src_h_d    = src_h_q;
    err_d      = err_q;
    acc_d      = acc_q;
    wr_data_d  = wr_data_q;
    w_clear    = 1'b0;
    w_rd_step  = 1'b0;
    w_wr_step  = 1'b0;
    rd_valid_d = (state_q == ST_READ);

    // each sample lands one cycle after its read strobe
    if (rd_valid_q) begin
      acc_d = acc_q + SUM_W'(rd_data);
    end

    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (start) begin
          mode_d  = scaler_mode_e'(mode);
          k_d     = (mode == 2'd3) ? 2'd0 : log2_factor;
          src_w_d = src_width;
          src_h_d = src_height;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_clear = 1'b1;
        acc_d   = '0;
        if (w_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        w_rd_step = 1'b1;
        if (w_rd_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wr_data_d = w_pix;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_ready) begin
          w_wr_step = 1'b1;
          acc_d     = '0;
          state_d   = w_wr_last ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_AVG_DOWN;
      k_q        <= '0;
      src_w_q    <= '0;
      src_h_q    <= '0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      src_w_q    <= src_w_d;
      src_h_q    <= src_h_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // ------------------------------------------------------------ addressing
  scaler_addr_gen #(
    .DIM_W    (DIM_W),
    .ADDR_W   (ADDR_W),
    .MAX_LOG2 (MAX_LOG2)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_clear),
    .rd_step    (w_rd_step),
    .wr_step    (w_wr_step),
    .mode       (mode_q),
    .k          (k_q),
    .src_width  (src_w_q),
    .out_width  (w_out_w),
    .out_height (w_out_h),
    .rd_addr    (w_rd_addr),
    .wr_addr    (w_wr_addr),
    .rd_last    (w_rd_last),
    .wr_last    (w_wr_last)
  );

  // --------------------------------------------------------------- outputs
  always_comb begin
    rd_en   = (state_q == ST_READ);
    wr_en   = (state_q == ST_WRITE);
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    err     = (state_q == ST_DONE) && err_q;
    rd_addr = rd_en ? w_rd_addr : '0;
    wr_addr = wr_en ? w_wr_addr : '0;
    wr_data = wr_en ? wr_data_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_image_scaler_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_scaler_engine
// Description : Directed self-checking bench for image_scaler_engine using a
//               4x2 source frame holding 1..8 in raster order.
// Config      : SCALER_ROUND_EN selects the rounded block-average results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_scaler_engine;

  localparam int PIX_W    = 8;
  localparam int DIM_W    = 10;
  localparam int ADDR_W   = 16;
  localparam int MAX_LOG2 = 3;
  localparam int MAX_CYC  = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [1:0]        log2_factor = 2'd0;
  logic [DIM_W-1:0]  src_width = '0;
  logic [DIM_W-1:0]  src_height = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready = 1'b1;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int rd_count;
  int stall_count;
  int frame_cycles;
  bit saw_err;
  bit aborted;

  always #5 clk = ~clk;

  image_scaler_engine #(
    .PIX_W    (PIX_W),
    .DIM_W    (DIM_W),
    .ADDR_W   (ADDR_W),
    .MAX_LOG2 (MAX_LOG2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .log2_factor (log2_factor),
    .src_width   (src_width),
    .src_height  (src_height),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Source frame: 4x2 pixels holding 1..8; anything else reads 0xEE.
  function automatic logic [PIX_W-1:0] src_pix(input int a);
    return (a < 8) ? PIX_W'(a + 1) : 8'hEE;
  endfunction

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= src_pix(int'(rd_addr));
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one frame and follow it to done. bp_n stalls the first write
  // that many cycles; rst_write > 0 asserts reset during that write.
  task automatic run_frame(input logic [1:0] m, input logic [1:0] k,
                           input int w, input int h,
                           input int bp_n, input int rst_write);
    int cyc;
    int bp_left;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    rd_count    = 0;
    stall_count = 0;
    saw_err     = 1'b0;
    aborted     = 1'b0;
    bp_left     = bp_n;
    @(negedge clk);
    start       = 1'b1;
    mode        = m;
    log2_factor = k;
    src_width   = DIM_W'(w);
    src_height  = DIM_W'(h);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // scramble inputs: the engine must work from its latched copy
        start       = 1'b0;
        mode        = ~m;
        log2_factor = ~k;
        src_width   = DIM_W'(1);
        src_height  = DIM_W'(3);
        check_val("busy_after_start", longint'(busy), 1);
      end
      if (cyc == 3) start = 1'b1;   // must be ignored while busy
      if (cyc == 4) start = 1'b0;
      if (rd_en) rd_count++;
      if (rst_write > 0 && wr_en && wq_addr.size() == rst_write - 1) begin
        rst_n = 1'b0;
        #1;
        check_val("reset_mid_frame_outputs",
                  longint'({rd_en, wr_en, busy, done, err, rd_addr, wr_addr, wr_data}), 0);
        aborted = 1'b1;
        break;
      end
      if (wr_en && bp_left > 0) begin
        wr_ready = 1'b0;
        bp_left--;
        stall_count++;
        check_val("stall_wr_addr", longint'(wr_addr), 0);
        check_val("stall_wr_data", longint'(wr_data), 1);
        check_val("stall_no_read", longint'(rd_en), 0);
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_en && wr_ready) begin
        wq_addr.push_back(int'(wr_addr));
        wq_data.push_back(int'(wr_data));
        wq_cyc.push_back(cyc);
      end
      if (done) begin
        saw_err = err;
        break;
      end
      if (cyc >= MAX_CYC) begin
        check_val("frame_timeout", longint'(cyc), 0);
        break;
      end
    end
    frame_cycles = cyc;
    wr_ready     = 1'b1;
  endtask

  initial begin
    int exp_a0;
    int exp_a1;
`ifdef SCALER_ROUND_EN
    exp_a0 = 4;
    exp_a1 = 6;
`else
    exp_a0 = 3;
    exp_a1 = 5;
`endif

    // ---- reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              longint'({rd_en, wr_en, busy, done, err, rd_addr, wr_addr, wr_data}), 0);
    rst_n = 1'b1;

    // ---- AVG k=1
    run_frame(2'd0, 2'd1, 4, 2, 0, 0);
    check_val("avg_nwrites", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check_val("avg_addr0", wq_addr[0], 0);
      check_val("avg_data0", wq_data[0], exp_a0);
      check_val("avg_addr1", wq_addr[1], 1);
      check_val("avg_data1", wq_data[1], exp_a1);
    end
    check_val("avg_cycles", frame_cycles, 14);
    check_val("avg_reads", rd_count, 8);
    check_val("avg_err", longint'(saw_err), 0);
    @(negedge clk);
    check_val("done_one_cycle", longint'({busy, done}), 0);

    // ---- DEC k=1
    run_frame(2'd1, 2'd1, 4, 2, 0, 0);
    check_val("dec_nwrites", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      check_val("dec_data0", wq_data[0], 1);
      check_val("dec_addr1", wq_addr[1], 1);
      check_val("dec_data1", wq_data[1], 3);
      check_val("dec_gap", wq_cyc[1] - wq_cyc[0], 3);
    end
    check_val("dec_cycles", frame_cycles, 8);

    // ---- REP k=1: 8x4 output
    run_frame(2'd2, 2'd1, 4, 2, 0, 0);
    check_val("rep_nwrites", wq_addr.size(), 32);
    if (wq_addr.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check_val($sformatf("rep_addr%0d", i), wq_addr[i], i);
        check_val($sformatf("rep_data%0d", i), wq_data[i],
                  ((i / 8) >> 1) * 4 + ((i % 8) >> 1) + 1);
      end
      check_val("rep_d9", wq_data[9], 1);
      check_val("rep_d31", wq_data[31], 8);
      check_val("rep_d6", wq_data[6], 4);
    end
    check_val("rep_cycles", frame_cycles, 98);

    // ---- REP with 5 cycles of backpressure on the first write
    run_frame(2'd2, 2'd1, 4, 2, 5, 0);
    check_val("bp_stalls", stall_count, 5);
    check_val("bp_nwrites", wq_addr.size(), 32);
    check_val("bp_cycles", frame_cycles, 103);

    // ---- rejected config: 2 rows not divisible by 4
    run_frame(2'd0, 2'd2, 4, 2, 0, 0);
    check_val("rej_cycles", frame_cycles, 2);
    check_val("rej_err", longint'(saw_err), 1);
    check_val("rej_reads", rd_count, 0);
    check_val("rej_writes", wq_addr.size(), 0);

    // ---- COPY of the same source (k input ignored)
    run_frame(2'd3, 2'd2, 4, 2, 0, 0);
    check_val("copy_nwrites", wq_addr.size(), 8);
    if (wq_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_val($sformatf("copy_data%0d", i), wq_data[i], i + 1);
      end
    end
    check_val("copy_cycles", frame_cycles, 26);
    check_val("copy_err", longint'(saw_err), 0);

    // ---- reset during the third REP write, then a full frame
    run_frame(2'd2, 2'd1, 4, 2, 0, 3);
    check_val("rst_taken", longint'(aborted), 1);
    repeat (2) @(negedge clk);
    check_val("rst_held_idle", longint'({busy, rd_en, wr_en}), 0);
    rst_n = 1'b1;
    run_frame(2'd2, 2'd1, 4, 2, 0, 0);
    check_val("post_rst_nwrites", wq_addr.size(), 32);
    if (wq_addr.size() == 32) begin
      check_val("post_rst_addr0", wq_addr[0], 0);
      check_val("post_rst_data0", wq_data[0], 1);
      check_val("post_rst_data31", wq_data[31], 8);
    end
    check_val("post_rst_cycles", frame_cycles, 98);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_scaler_engine.md
# image_scaler_engine

Parametrised streaming scaler that merges row/column generation and pixel arithmetic into one engine with runtime-selectable power-of-two factor (1, 2, 4, 8) and four modes: block-average downscale, decimation downscale, replication upscale and copy. It sits between the source frame memory (1-cycle read latency) and the output frame buffer. It takes a start/busy/done handshake from the host controller and honours write backpressure.

## Interface
- PIX_W, 8, pixel width in bits
- DIM_W, 10, width of source dimension inputs
- ADDR_W, 16, read/write address width
- MAX_LOG2, 3, largest supported log2 factor

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch pulse; sampled only in IDLE
- mode  in  2  0 AVG_DOWN, 1 DEC_DOWN, 2 REP_UP, 3 COPY
- log2_factor  in  2  k; factor F = 2^k; ignored in COPY
- src_width, src_height  in  DIM_W  source dimensions in pixels
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source address, sy*src_width+sx
- rd_data  in  PIX_W  valid the cycle after rd_en
- wr_en  out  1  output write request
- wr_addr  out  ADDR_W  output address, oy*out_width+ox
- wr_data  out  PIX_W  output pixel
- wr_ready  in  1  sink accepts write on edge where wr_en&&wr_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end
- err  out  1  one-cycle pulse with done on rejected config

## Operation
- On start in IDLE, latch mode, k, src_width and src_height; inputs may change afterwards.
- Output dimensions:
  - AVG/DEC: W>>k, H>>k.
  - REP: W<<k, H<<k.
  - COPY: W, H.
- Reject the config if any of these hold: a dimension is zero; k>MAX_LOG2; a downscale dimension is not divisible by F; or out_width*out_height > 2^ADDR_W. A rejected config goes CHECK -> DONE with err=1 and produces no reads or writes.
- Output pixels are written in raster order, ox fastest.
- Reads per output pixel, N:
  - AVG: F*F reads of block (ox<<k+dx, oy<<k+dy), dx fastest. Sum width is PIX_W+2*MAX_LOG2; result = sum>>2k.
  - DEC: 1 read at (ox<<k, oy<<k).
  - REP: 1 read at (ox>>k, oy>>k).
  - COPY: 1 read at (ox, oy).
- FSM: IDLE -> CHECK -> READ -> DRAIN -> WRITE -> (READ for the next pixel | DONE) -> IDLE.
- READ: rd_en=1 for exactly N consecutive cycles. Each rd_data is captured or accumulated the cycle after its rd_en. The accumulator clears on entry to READ.
- DRAIN: captures the last rd_data and registers wr_data.
- WRITE: wr_en=1. wr_addr and wr_data are held stable until wr_ready. No reads are issued while in WRITE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- Async reset at any point returns the block to IDLE. The partial frame is abandoned; a new start begins again at pixel 0.

## Timing
- Reset values: all outputs 0. FSM in IDLE, counters 0, accumulator 0.
- start at edge t gives busy=1 from t+1 (CHECK); first rd_en at t+2.
- Per output pixel with no backpressure: N+2 cycles (N READ, 1 DRAIN, 1 WRITE).
- Each cycle wr_ready is low in WRITE adds one cycle.
- done follows the last accepted write by one cycle. busy falls in the same cycle done falls.
- Rejected config: done and err pulse 2 cycles after the start edge.

## Configuration
- SCALER_ROUND_EN defined: AVG result = (sum + (1<<(2k-1)))>>2k for k>0, i.e. round-half-up.
- Undefined: truncation, sum>>2k.
- No other mode is affected.

## Structure
- scaler_pkg holds the mode enum, the FSM state enum, the ACC_W = PIX_W+2*MAX_LOG2 constant and the helper function for output dimensions.
- Sub-module scaler_addr_gen holds the ox/oy/dx/dy counters and the rd_addr/wr_addr multiply-add logic. It advances on read and accept strobes from the FSM.

## Test plan
- AVG, k=1, 4x2 source 1..8 raster: writes (0,3),(1,5); with SCALER_ROUND_EN, (0,4),(1,6). Frame takes 2*(4+2)+2 cycles.
- DEC, k=1, same source: writes (0,1),(1,3), each 3 cycles apart.
- REP, k=1, same source: 32 writes; addr 0=1, addr 9=1, addr 31=8, addr 6=4.
- Backpressure: wr_ready held low 5 cycles on the first REP write: wr_en, wr_addr and wr_data stay stable, no rd_en, and the frame grows by exactly 5 cycles.
- Error: AVG, k=2, 4x2 source: done=err=1 two cycles after start, zero rd_en and zero wr_en. COPY of the same source gives 8 writes with wr_data equal to the source.
- Reset mid-frame: rst_n low during the 3rd REP write: all outputs 0 immediately. After release, start yields the full 32-write frame beginning at addr 0.
